bus_slave_regbank: RTL and testbench

Slave (responder) end of the CPU-side strobe/acknowledge bus. It accepts a strobed request from the CPU bus interface, inserts a programmable number of wait states, and returns a one-cycle acknowledge with read data. It fronts a small bank of 32-bit registers with byte-lane writes. It is the reusable template for memory-mapped peripherals on the CPU bus.

---
 rtl/bus_slave_regbank.sv | 162 ++++++++++++++++
 tb/tb_bus_slave_regbank.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_regbank.sv
// bus_slave_regbank: strobe/ack bus responder with wait states
// in front of a bank of byte-writable 32-bit registers.
//
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   cs_i, stb_i, we_i  select, request strobe, write enable
//   adr_i, dat_i       byte address, write data
//   sel_i              byte-lane enables
//   ack_o              one-cycle registered acknowledge
//   dat_o              registered read data (held between reads)
module bus_slave_regbank #(
  parameter int          ADDR_W      = 3,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h4D495053
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] dat_o
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        sel_q, sel_d;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic [31:0]       regs_q [NREG];

  // Transaction view at the commit edge. With no wait
  // states the commit edge is the capture edge, so the
  // live inputs are used instead of the latched copies.
  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_idx;
  logic [31:0]       c_dat;
  logic [3:0]        c_sel;
  logic [31:0]       rd_val;

  logic unused_adr;
  assign unused_adr = ^{adr_i[31:ADDR_W+2], adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_idx   = idx_q;
    c_dat   = wdat_q;
    c_sel   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (cs_i && stb_i) begin
          we_d   = we_i;
          idx_d  = adr_i[ADDR_W+1:2];
          wdat_d = dat_i;
          sel_d  = sel_i;
          cnt_d  = WAIT_CNT;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
            c_we    = we_i;
            c_idx   = adr_i[ADDR_W+1:2];
            c_dat   = dat_i;
            c_sel   = sel_i;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stb_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end
        end
      end
      S_ACK: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!stb_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_val = regs_q[c_idx];
    if (c_idx == '0) rd_val = ID_VALUE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      // ack follows the ACK state by one edge
      ack_q   <= (state_q == S_ACK);
      if (commit && !c_we) dat_q <= rd_val;
    end
  end

  // Register 0 is the read-only ID; its storage stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (commit && c_we && c_idx != '0) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) begin
          regs_q[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
        end
      end
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

endmodule

// File: tb/tb_bus_slave_regbank.sv
// tb_bus_slave_regbank: scoreboard bench driving two slaves
// (0 and 3 wait states) on a shared bus, split by chip select.
module tb_bus_slave_regbank;

  localparam int AW = 3;
  localparam int NR = 1 << AW;
  localparam logic [31:0] ID = 32'h4D495053;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs0 = 1'b0;
  logic        cs3 = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        ack0, ack3;
  logic [31:0] do0, do3;

  always #5 clk = ~clk;

  bus_slave_regbank #(
    .ADDR_W(AW), .WAIT_CYCLES(0), .ID_VALUE(ID)
  ) u_w0 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs0),
    .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel),
    .ack_o(ack0), .dat_o(do0)
  );

  bus_slave_regbank #(
    .ADDR_W(AW), .WAIT_CYCLES(3), .ID_VALUE(ID)
  ) u_w3 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs3),
    .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel),
    .ack_o(ack3), .dat_o(do3)
  );

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  exp_t        e0, e3;
  logic [31:0] mem [2][NR];
  logic [31:0] last [2];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w0 ack: got ack_o=1 want no ack");
      end else begin
        e0 = q0.pop_front();
        check("w0 dat_o", do0, e0.dat);
        check("w0 ack cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ack3 === 1'b1) begin
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w3 ack: got ack_o=1 want no ack");
      end else begin
        e3 = q3.pop_front();
        check("w3 dat_o", do3, e3.dat);
        check("w3 ack cycle", cyc, e3.cyc);
      end
    end
  end

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      last[k] = '0;
      for (int i = 0; i < NR; i++) mem[k][i] = '0;
    end
    q0.delete();
    q3.delete();
  endtask

  function automatic logic [31:0] rnd_adr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = idx[AW-1:0];
    return a;
  endfunction

  // Full handshake: issue, hold stb until ack, then
  // keep stb high for `hold` more cycles and release.
  task automatic xfer(input bit d3, input bit w,
                      input int idx,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input int hold);
    exp_t e;
    int   k;
    bit   got;
    k = d3 ? 1 : 0;
    if (w) begin
      if (idx != 0) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[k][idx][8*b +: 8] = d[8*b +: 8];
      end
      e.dat = last[k];
    end else begin
      e.dat = (idx == 0) ? ID : mem[k][idx];
      last[k] = e.dat;
    end
    e.cyc = cyc + (d3 ? 3 : 0) + 2;
    if (d3) q3.push_back(e);
    else    q0.push_back(e);
    adr = rnd_adr(idx);
    dat = d;
    sel = s;
    we  = w;
    cs0 = !d3;
    cs3 = d3;
    stb = 1'b1;
    @(negedge clk);
    // inputs must not be re-sampled after capture
    cs0 = 1'b0;
    cs3 = 1'b0;
    adr = $urandom;
    dat = $urandom;
    sel = 4'($urandom);
    we  = 1'($urandom);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if ((d3 ? ack3 : ack0) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack timeout: got no ack want ack");
    end
    repeat (hold + 1) @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    repeat (3) @(negedge clk);
    check("reset ack0", {31'b0, ack0}, 32'h0);
    check("reset dat0", do0, 32'h0);
    check("reset ack3", {31'b0, ack3}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    xfer(1'b0, 1'b0, 0, '0, 4'h0, 0);
    xfer(1'b0, 1'b0, 5, '0, 4'h0, 0);
    xfer(1'b1, 1'b0, 0, '0, 4'h0, 0);

    xfer(1'b0, 1'b1, 2, 32'hDEADBEEF, 4'hF, 0);
    xfer(1'b0, 1'b0, 2, '0, 4'h0, 0);

    xfer(1'b0, 1'b1, 3, 32'h11223344, 4'hF, 0);
    xfer(1'b0, 1'b1, 3, 32'hAABBCCDD, 4'b0101, 0);
    xfer(1'b0, 1'b0, 3, '0, 4'h0, 0);
    check("lane merge model", mem[0][3], 32'h11BB33DD);

    xfer(1'b1, 1'b1, 0, 32'hFFFFFFFF, 4'hF, 0);
    xfer(1'b1, 1'b0, 0, '0, 4'h0, 0);

    // abort a write after one wait cycle
    xfer(1'b1, 1'b1, 1, 32'h00001234, 4'hF, 0);
    adr = rnd_adr(1);
    dat = 32'h5;
    sel = 4'hF;
    we  = 1'b1;
    cs3 = 1'b1;
    stb = 1'b1;
    @(negedge clk);
    cs3 = 1'b0;
    @(negedge clk);
    stb = 1'b0;
    repeat (8) @(negedge clk);
    xfer(1'b1, 1'b0, 1, '0, 4'h0, 0);

    // strobe held after ack: one ack only
    xfer(1'b1, 1'b1, 2, 32'hCAFEF00D, 4'hF, 5);
    xfer(1'b1, 1'b0, 2, '0, 4'h0, 5);
    xfer(1'b0, 1'b0, 2, '0, 4'h0, 5);

    // asynchronous reset while ack is high
    xfer(1'b0, 1'b0, 0, '0, 4'h0, 0);
    adr = rnd_adr(2);
    we  = 1'b0;
    cs0 = 1'b1;
    stb = 1'b1;
    q0.push_back('{dat: mem[0][2], cyc: cyc + 2});
    @(negedge clk);
    cs0 = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ack0", {31'b0, ack0}, 32'h0);
    check("async rst dat0", do0, 32'h0);
    stb = 1'b0;
    mreset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset during wait states drops the write
    xfer(1'b1, 1'b1, 4, 32'h00000011, 4'hF, 0);
    adr = rnd_adr(4);
    dat = 32'h77;
    sel = 4'hF;
    we  = 1'b1;
    cs3 = 1'b1;
    stb = 1'b1;
    @(negedge clk);
    cs3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stb = 1'b0;
    #1;
    check("wait rst ack3", {31'b0, ack3}, 32'h0);
    mreset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    xfer(1'b1, 1'b0, 4, '0, 4'h0, 0);

    // strobe without chip select
    stb = 1'b1;
    we  = 1'b1;
    adr = rnd_adr(6);
    dat = 32'h12345678;
    sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no cs ack", {31'b0, ack0 | ack3}, 32'h0);
    end
    stb = 1'b0;
    @(negedge clk);
    xfer(1'b0, 1'b0, 6, '0, 4'h0, 0);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(3) == 0)
        repeat ($urandom_range(2)) @(negedge clk);
      xfer(1'($urandom), 1'($urandom),
           int'($urandom_range(NR - 1)),
           $urandom, 4'($urandom),
           int'($urandom_range(3)));
    end

    repeat (4) @(negedge clk);
    check("w0 queue drained", q0.size(), 32'h0);
    check("w3 queue drained", q3.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
